mini_alu_core: RTL and testbench

//  Parametrised successor to the MiniAlu datapath: fetch/execute sequencer, ALU, internal return-address stack.

---
 rtl/mini_alu_core_if.sv | 15 +
 rtl/mini_alu_core.sv | 176 +++++++++++++++++
 tb/tb_mini_alu_core.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_alu_core_if.sv
// Peripheral request channel of mini_alu_core: core drives request/channel/address/data, peripheral returns ready.
// Transfer completes on any cycle where oPerValid && iPerReady; master holds all fields stable until then.
interface mini_alu_core_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic              oPerValid;
    logic [CH_W-1:0]   oPerCh;
    logic [DATA_W-1:0] oPerAddr;
    logic [DATA_W-1:0] oPerData;
    logic              iPerReady;

    modport master (output oPerValid, oPerCh, oPerAddr, oPerData, input iPerReady);
    modport slave  (input  oPerValid, oPerCh, oPerAddr, oPerData, output iPerReady);
endinterface

// File: rtl/mini_alu_core.sv
// Fetch/execute core with ALU, return-address stack and valid/ready peripheral port; optional MINI_ALU_CORE_SAT_EN.
// Latency: 2 cycles per instruction (FETCH, EXEC); OUT stalls in WAIT until the peripheral is ready.
// Backpressure: iPerReady low freezes IP/IR and holds the request stable; RAS misuse faults and halts.
module mini_alu_core #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int IP_W      = 16,
    parameter int RAS_DEPTH = 8,
    parameter int CH_W      = 2
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    output logic [IP_W-1:0]       oIP,
    input  logic [4+3*ADDR_W-1:0] iInstruction,
    output logic [ADDR_W-1:0]     oRdAddr0,
    output logic [ADDR_W-1:0]     oRdAddr1,
    input  logic [DATA_W-1:0]     iRdData0,
    input  logic [DATA_W-1:0]     iRdData1,
    output logic                  oWrEn,
    output logic [ADDR_W-1:0]     oWrAddr,
    output logic [DATA_W-1:0]     oWrData,
    mini_alu_core_if.master       per_if,
    output logic                  oHalted,
    output logic                  oFault
);
    localparam int IW    = 4 + 3 * ADDR_W;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_STO  = 4'h4;
    localparam logic [3:0] OP_BLE  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;
    localparam logic [3:0] OP_RET  = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [IP_W-1:0]   ip_q, ip_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [PTR_W:0]    ras_ptr_q, ras_ptr_d;
    logic              fault_q, fault_d;
    logic [IP_W-1:0]   ras_mem [RAS_DEPTH];

    logic              ras_push;
    logic              wr_en;
    logic [DATA_W-1:0] wr_dat;
    logic              per_vld;
    logic [DATA_W-1:0] add_res, sub_res;

    logic [3:0]        op;
    logic [ADDR_W-1:0] dest, src1, src0;
    logic [DATA_W-1:0] imm, r1, r0;
    logic [PTR_W:0]    ras_ptr_dec;

    assign op          = ir_q[IW-1 -: 4];
    assign dest        = ir_q[3*ADDR_W-1 -: ADDR_W];
    assign src1        = ir_q[2*ADDR_W-1 -: ADDR_W];
    assign src0        = ir_q[ADDR_W-1:0];
    assign imm         = DATA_W'({src1, src0});
    assign r1          = iRdData1;
    assign r0          = iRdData0;
    assign ras_ptr_dec = ras_ptr_q - PTR_ONE;

`ifdef MINI_ALU_CORE_SAT_EN
    logic [DATA_W:0] add_wide;
    assign add_wide = {1'b0, r1} + {1'b0, r0};
    assign add_res  = add_wide[DATA_W] ? '1 : add_wide[DATA_W-1:0];
    assign sub_res  = (r1 < r0) ? '0 : r1 - r0;
`else
    assign add_res  = r1 + r0;
    assign sub_res  = r1 - r0;
`endif

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        ir_d      = ir_q;
        ras_ptr_d = ras_ptr_q;
        fault_d   = fault_q;
        ras_push  = 1'b0;
        wr_en     = 1'b0;
        wr_dat    = '0;
        per_vld   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = iInstruction;
                ip_d    = ip_q + IP_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD: begin wr_en = 1'b1; wr_dat = add_res; end
                    OP_SUB: begin wr_en = 1'b1; wr_dat = sub_res; end
                    OP_MUL: begin wr_en = 1'b1; wr_dat = r1 * r0; end
                    OP_STO: begin wr_en = 1'b1; wr_dat = imm; end
                    OP_BLE: if (r1 <= r0) ip_d = IP_W'(dest);
                    OP_JMP: ip_d = IP_W'(imm);
                    OP_CALL: begin
                        if (ras_ptr_q == RAS_FULL) begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            ras_push  = 1'b1;
                            ras_ptr_d = ras_ptr_q + PTR_ONE;
                            ip_d      = IP_W'(imm);
                        end
                    end
                    OP_RET: begin
                        if (ras_ptr_q == '0) begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            ras_ptr_d = ras_ptr_dec;
                            ip_d      = ras_mem[ras_ptr_dec[PTR_W-1:0]];
                        end
                    end
                    OP_OUT: begin
                        per_vld = 1'b1;
                        if (!per_if.iPerReady) state_d = S_WAIT;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_WAIT: begin
                per_vld = 1'b1;
                if (per_if.iPerReady) state_d = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_FETCH;
            ip_q      <= '0;
            ir_q      <= '0;
            ras_ptr_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            ir_q      <= ir_d;
            ras_ptr_q <= ras_ptr_d;
            fault_q   <= fault_d;
        end
    end

    // Stack storage survives reset; only the pointer is cleared.
    always_ff @(posedge Clock) begin
        if (ras_push) ras_mem[ras_ptr_q[PTR_W-1:0]] <= ip_q;
    end

    assign oIP      = ip_q;
    assign oRdAddr0 = src0;
    assign oRdAddr1 = src1;
    assign oWrEn    = wr_en;
    assign oWrAddr  = dest;
    assign oWrData  = wr_dat;
    assign oHalted  = (state_q == S_HALT);
    assign oFault   = fault_q;

    assign per_if.oPerValid = per_vld;
    assign per_if.oPerCh    = per_vld ? dest[CH_W-1:0] : '0;
    assign per_if.oPerAddr  = per_vld ? r0 : '0;
    assign per_if.oPerData  = per_vld ? r1 : '0;
endmodule

// File: tb/tb_mini_alu_core.sv
// Directed bench for mini_alu_core: ROM/RAM models, ALU vector table, hand sequences for branch/RAS/OUT/reset.
module tb_mini_alu_core;
    localparam int DATA_W = 16, ADDR_W = 8, IP_W = 16, RAS_DEPTH = 8, CH_W = 2;
`ifdef MINI_ALU_CORE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b1;
    logic [IP_W-1:0]   oIP;
    logic [27:0]       iInstruction;
    logic [7:0]        oRdAddr0, oRdAddr1, oWrAddr;
    logic [15:0]       iRdData0, iRdData1, oWrData;
    logic              oWrEn, oHalted, oFault;

    always #5 Clock = ~Clock;

    mini_alu_core_if #(.DATA_W(DATA_W), .CH_W(CH_W)) per_if ();

    mini_alu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IP_W(IP_W), .RAS_DEPTH(RAS_DEPTH), .CH_W(CH_W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .oIP(oIP), .iInstruction(iInstruction),
        .oRdAddr0(oRdAddr0), .oRdAddr1(oRdAddr1), .iRdData0(iRdData0), .iRdData1(iRdData1),
        .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData), .per_if(per_if),
        .oHalted(oHalted), .oFault(oFault)
    );

    logic [27:0] rom [0:255];
    logic [15:0] ram [0:255];
    assign iInstruction = rom[oIP[7:0]];
    assign iRdData0     = ram[oRdAddr0];
    assign iRdData1     = ram[oRdAddr1];
    always @(posedge Clock) if (oWrEn) ram[oWrAddr] <= oWrData;

    int checks = 0, failures = 0;
    int wr_cnt, per_cnt;
    logic [15:0] ip_trace [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] enc(input logic [3:0] op, input logic [7:0] d, input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic enter_reset();
        Reset_n = 1'b0;
        per_if.iPerReady = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = enc(4'hF, 8'h00, 8'h00, 8'h00);
        @(negedge Clock);
    endtask

    task automatic release_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    // Samples one point per cycle, 1ns after the falling edge, until the core halts.
    task automatic run(input string name, input int bound);
        bit done = 1'b0;
        wr_cnt = 0;
        per_cnt = 0;
        for (int i = 0; i < 64; i++) ip_trace[i] = 16'hxxxx;
        for (int k = 0; k < bound; k++) begin
            #1;
            if (k < 64) ip_trace[k] = oIP;
            if (oWrEn) wr_cnt++;
            if (per_if.oPerValid) per_cnt++;
            if (oHalted) begin done = 1'b1; break; end
            @(negedge Clock);
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int bound, output int cyc);
        cyc = -1;
        for (int k = 0; k < bound; k++) begin
            #1;
            if (per_if.oPerValid) begin cyc = k; break; end
            @(negedge Clock);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          wrs;
        string       name;
    } vec_t;
    vec_t vecs [12];

    task automatic set_vec(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input int wrs, input string name);
        vecs[i].op = op; vecs[i].a = a; vecs[i].b = b; vecs[i].exp = exp; vecs[i].wrs = wrs; vecs[i].name = name;
    endtask

    task automatic ble_case(input logic [15:0] r1v, input logic [15:0] exp_ip, input logic [15:0] exp_r5,
                            input logic [15:0] exp_end);
        enter_reset();
        rom[0] = enc(4'h4, 8'd1, r1v[15:8], r1v[7:0]);
        rom[1] = enc(4'h4, 8'd2, 8'h00, 8'h05);
        rom[2] = enc(4'h5, 8'h20, 8'd1, 8'd2);
        rom[3] = enc(4'h4, 8'd5, 8'h03, 8'h33);
        rom[8'h20] = enc(4'h4, 8'd5, 8'h00, 8'h20);
        release_reset();
        run("ble_halt", 40);
        check("ble_next_ip", 32'(ip_trace[6]), 32'(exp_ip));
        check("ble_r5", 32'(ram[5]), 32'(exp_r5));
        check("ble_end_ip", 32'(oIP), 32'(exp_end));
    endtask

    initial begin
        int cyc, good;
        set_vec(0,  4'h1, 16'hFFFF, 16'h0002, SAT ? 16'hFFFF : 16'h0001, 4, "add_carry");
        set_vec(1,  4'h1, 16'h1234, 16'h1111, 16'h2345, 4, "add_plain");
        set_vec(2,  4'h1, 16'h8000, 16'h8000, SAT ? 16'hFFFF : 16'h0000, 4, "add_msb");
        set_vec(3,  4'h2, 16'h0002, 16'hFFFF, SAT ? 16'h0000 : 16'h0003, 4, "sub_borrow");
        set_vec(4,  4'h2, 16'h5000, 16'h1234, 16'h3DCC, 4, "sub_plain");
        set_vec(5,  4'h2, 16'h0007, 16'h0007, 16'h0000, 4, "sub_equal");
        set_vec(6,  4'h3, 16'h0100, 16'h0100, 16'h0000, 4, "mul_wrap");
        set_vec(7,  4'h3, 16'h00FF, 16'h0003, 16'h02FD, 4, "mul_plain");
        set_vec(8,  4'h3, 16'hFFFF, 16'hFFFF, 16'h0001, 4, "mul_max");
        set_vec(9,  4'h4, 16'h1111, 16'h2222, 16'h0102, 4, "sto_imm");
        set_vec(10, 4'h0, 16'h1111, 16'h2222, 16'hDEAD, 3, "nop");
        set_vec(11, 4'hC, 16'h1111, 16'h2222, 16'hDEAD, 3, "undef_op");

        // Reset state
        #1 Reset_n = 1'b0;
        per_if.iPerReady = 1'b0;
        #1;
        check("reset_outputs_zero",
              32'(|{oIP, oWrEn, oWrAddr, oWrData, oRdAddr0, oRdAddr1, oHalted, oFault,
                    per_if.oPerValid, per_if.oPerCh, per_if.oPerAddr, per_if.oPerData}), 32'd0);

        // ALU / STO table
        for (int v = 0; v < 12; v++) begin
            enter_reset();
            rom[0] = enc(4'h4, 8'd3, 8'hDE, 8'hAD);
            rom[1] = enc(4'h4, 8'd1, vecs[v].a[15:8], vecs[v].a[7:0]);
            rom[2] = enc(4'h4, 8'd2, vecs[v].b[15:8], vecs[v].b[7:0]);
            rom[3] = enc(vecs[v].op, 8'd3, 8'd1, 8'd2);
            release_reset();
            run({vecs[v].name, "_halt"}, 40);
            check({vecs[v].name, "_result"}, 32'(ram[3]), 32'(vecs[v].exp));
            check({vecs[v].name, "_writes"}, 32'(wr_cnt), 32'(vecs[v].wrs));
            check({vecs[v].name, "_end_ip"}, 32'(oIP), 32'h5);
        end
        check("two_cycle_cadence", 32'(ip_trace[2]), 32'h1);

        // Branch taken on equality, not taken when R1 > R0
        ble_case(16'h0005, 16'h0020, 16'h0020, 16'h0022);
        ble_case(16'h0006, 16'h0003, 16'h0333, 16'h0005);

        // CALL then RET returns to the word after the CALL
        enter_reset();
        rom[0]     = enc(4'h6, 8'h00, 8'h00, 8'h10);
        rom[8'h10] = enc(4'h7, 8'h00, 8'h00, 8'h40);
        rom[8'h11] = enc(4'h4, 8'd6, 8'h11, 8'h11);
        rom[8'h40] = enc(4'h4, 8'd7, 8'h40, 8'h40);
        rom[8'h41] = enc(4'h8, 8'h00, 8'h00, 8'h00);
        release_reset();
        run("call_halt", 60);
        check("call_fetch_ip", 32'(ip_trace[2]), 32'h10);
        check("call_exec_ip", 32'(ip_trace[3]), 32'h11);
        check("call_target_ip", 32'(ip_trace[4]), 32'h40);
        check("ret_target_ip", 32'(ip_trace[8]), 32'h11);
        check("call_body_write", 32'(ram[7]), 32'h4040);
        check("ret_path_write", 32'(ram[6]), 32'h1111);
        check("call_no_fault", 32'(oFault), 32'd0);

        // RAS_DEPTH+1 nested calls: the last one faults
        enter_reset();
        for (int k = 0; k <= RAS_DEPTH; k++) rom[k] = enc(4'h7, 8'h00, 8'h00, 8'(k + 1));
        release_reset();
        run("ovf_halt", 80);
        check("ovf_fault", 32'(oFault), 32'd1);
        check("ovf_ip_held", 32'(oIP), 32'(RAS_DEPTH + 1));

        // RET on an empty stack
        enter_reset();
        rom[0] = enc(4'h8, 8'h00, 8'h00, 8'h00);
        release_reset();
        run("unf_halt", 20);
        check("unf_fault", 32'(oFault), 32'd1);
        check("unf_ip_held", 32'(oIP), 32'h1);
        check("unf_no_write", 32'(wr_cnt), 32'd0);
        Reset_n = 1'b0;
        #1;
        check("fault_async_clear", 32'(oFault), 32'd0);

        // OUT accepted in the same cycle
        enter_reset();
        rom[0] = enc(4'h4, 8'd0, 8'h00, 8'h07);
        rom[1] = enc(4'h4, 8'd1, 8'h00, 8'h41);
        rom[2] = enc(4'h9, 8'd2, 8'd1, 8'd0);
        rom[3] = enc(4'h4, 8'd5, 8'h55, 8'h55);
        release_reset();
        per_if.iPerReady = 1'b1;
        run("out_fast_halt", 40);
        check("out_fast_valid_cycles", 32'(per_cnt), 32'd1);
        check("out_fast_end_ip", 32'(oIP), 32'h5);

        // OUT stalled for 5 cycles
        Reset_n = 1'b0;
        per_if.iPerReady = 1'b0;
        ram[5] = 16'h0000;
        release_reset();
        wait_valid(20, cyc);
        check("out_first_valid_cycle", 32'(cyc), 32'd5);
        good = 0;
        for (int i = 0; i < 6; i++) begin
            if (per_if.oPerValid && per_if.oPerCh == 2'd2 && per_if.oPerAddr == 16'h0007 &&
                per_if.oPerData == 16'h0041 && oIP == 16'h3 && !oWrEn) good++;
            if (i == 5) per_if.iPerReady = 1'b1;
            @(negedge Clock);
            #1;
        end
        per_if.iPerReady = 1'b0;
        check("out_hold_cycles", 32'(good), 32'd6);
        check("out_released", 32'(per_if.oPerValid), 32'd0);
        run("out_slow_halt", 40);
        check("out_slow_resume", 32'(ram[5]), 32'h5555);

        // Reset asserted while waiting on the peripheral
        enter_reset();
        rom[0] = enc(4'h4, 8'd0, 8'h00, 8'h07);
        rom[1] = enc(4'h9, 8'd1, 8'd1, 8'd0);
        release_reset();
        wait_valid(20, cyc);
        @(negedge Clock);
        #1;
        check("wait_valid_held", 32'(per_if.oPerValid), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("wait_reset_drops_valid", 32'(per_if.oPerValid), 32'd0);
        release_reset();
        #1;
        check("wait_reset_ip", 32'(oIP), 32'h0);
        check("wait_reset_fault", 32'(oFault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
